// File: rtl/adc_frame_uplink.sv
// adc_frame_uplink: captures a burst of 10-bit ADC samples and streams each one
// to the host through the JTAG UART data register as two tagged bytes
// (LSB tag 3'b000, MSB tag 3'b111), waiting for a per-sample ack byte.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for start
// S_CAPTURE  | storing sample_valid strobes until the buffer is full
// S_SEND_LSB | Avalon write of {3'b000, sample[4:0]}
// S_SEND_MSB | Avalon write of {3'b111, sample[9:5]}
// S_WAIT_ACK | polling the data register for an ack byte, timeout running
// S_DONE     | one-cycle done pulse after the last ack
// S_ERROR    | retries exhausted; sticky until start or reset
module adc_frame_uplink #(
  parameter int DEPTH       = 32,
  parameter int ACK_TIMEOUT = 50000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic                     i_sample_valid,
  input  logic [9:0]               i_sample_data,
  output logic                     o_av_write,
  output logic                     o_av_read,
  output logic [31:0]              o_av_writedata,
  input  logic [31:0]              i_av_readdata,
  input  logic                     i_av_waitrequest,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [$clog2(DEPTH):0]   o_captured,
  output logic [$clog2(DEPTH)-1:0] o_tx_index
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [AW:0]   CAP_LAST  = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_SEND_LSB, S_SEND_MSB, S_WAIT_ACK, S_DONE, S_ERROR
  } state_t;

  state_t        r_state;
  logic [9:0]    r_buf [DEPTH];
  logic [AW:0]   r_captured;
  logic [AW-1:0] r_tx_index;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_timer;
  logic          r_av_write;
  logic          r_av_read;
  logic [7:0]    r_byte;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic [9:0]    w_sample;
  logic [7:0]    w_lsb_byte;
  logic [7:0]    w_msb_byte;
  logic          w_cap_we;
  logic          w_rd_xfer;
  logic          w_ack;
  logic          w_timeout;
  logic [RW-1:0] w_retry_next;
  logic          w_unused_rd;

  assign w_sample     = r_buf[r_tx_index];
  assign w_lsb_byte   = {3'b000, w_sample[4:0]};
  assign w_msb_byte   = {3'b111, w_sample[9:5]};
  assign w_cap_we     = (r_state == S_CAPTURE) && i_sample_valid;
  assign w_rd_xfer    = r_av_read && !i_av_waitrequest;
  assign w_ack        = i_av_readdata[15] && (i_av_readdata[7:6] == 2'b10);
  assign w_timeout    = (r_timer == TO_LAST);
  assign w_retry_next = r_retry + 1'b1;
  // Only RVALID and the tag bits of the received byte matter here.
  assign w_unused_rd  = ^{i_av_readdata[31:16], i_av_readdata[14:8], i_av_readdata[5:0]};

  assign o_av_write     = r_av_write;
  assign o_av_read      = r_av_read;
  assign o_av_writedata = {24'h000000, r_byte};
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_captured     = r_captured;
  assign o_tx_index     = r_tx_index;

  // Sample buffer; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (w_cap_we) r_buf[r_captured[AW-1:0]] <= i_sample_data;
  end

  // Sequencer: capture, byte writes, ack polling with timeout/retry.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_captured <= '0;
      r_tx_index <= '0;
      r_retry    <= '0;
      r_timer    <= '0;
      r_av_write <= 1'b0;
      r_av_read  <= 1'b0;
      r_byte     <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (i_start) begin
            r_captured <= '0;
            r_tx_index <= '0;
            r_retry    <= '0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (i_sample_valid) begin
            r_captured <= r_captured + 1'b1;
            if (r_captured == CAP_LAST) r_state <= S_SEND_LSB;
          end
        end
        // Write is raised one cycle after entry, which gives the mandatory
        // idle cycle between back-to-back writes and after a read.
        S_SEND_LSB: begin
          if (!r_av_write) begin
            r_av_write <= 1'b1;
            r_byte     <= w_lsb_byte;
          end else if (!i_av_waitrequest) begin
            r_av_write <= 1'b0;
            r_state    <= S_SEND_MSB;
          end
        end
        S_SEND_MSB: begin
          if (!r_av_write) begin
            r_av_write <= 1'b1;
            r_byte     <= w_msb_byte;
          end else if (!i_av_waitrequest) begin
            r_av_write <= 1'b0;
            r_timer    <= '0;
            r_state    <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          // Saturating: an expiry seen during a stalled read is held until
          // that read finishes.
          if (!w_timeout) r_timer <= r_timer + 1'b1;
          if (w_rd_xfer) r_av_read <= 1'b0;
          if (w_rd_xfer && w_ack) begin
            r_retry <= '0;
            if (r_tx_index == IDX_LAST) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_tx_index <= r_tx_index + 1'b1;
              r_state    <= S_SEND_LSB;
            end
          end else if (w_timeout && (!r_av_read || w_rd_xfer)) begin
            r_retry <= w_retry_next;
            if (w_retry_next == RETRY_MAX) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_ERROR;
            end else begin
              r_state <= S_SEND_LSB;
            end
          end else if (!r_av_read) begin
            r_av_read <= 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/adc_frame_uplink.md
Name: adc_frame_uplink

Overview:
- Sits between adc_dac_control and the uart_jtag Avalon slave.
- Captures a burst of DEPTH 10-bit ADC CH1 samples on the store_trigger strobe into an internal buffer.
- Streams each sample to the laptop as two tagged bytes over the JTAG UART data register.
- Waits for a per-sample acknowledge byte from the laptop before sending the next sample; on timeout it resends the sample, and after MAX_RETRY timeouts it flags an error.

Parameters:
- DEPTH, 32, samples per burst; power of two, at least 2.
- ACK_TIMEOUT, 50000000, cycles in WAIT_ACK before one retry (1 s at 50 MHz).
- MAX_RETRY, 3, number of timeouts on one sample before entering ERROR.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; arms a new capture (honoured only in IDLE or ERROR)
- sample_valid  in  1  store_trigger from adc_dac_control; one-cycle strobe per sample
- sample_data  in  10  output_ADC_CH1; valid in the cycle sample_valid=1
- av_write  out  1  Avalon write to JTAG UART data register (address 0)
- av_read  out  1  Avalon read from JTAG UART data register
- av_writedata  out  32  bits [7:0] carry the byte; bits [31:8] are always 0
- av_readdata  in  32  bit 15 = RVALID; bits [7:0] = received byte
- av_waitrequest  in  1  slave stall
- busy  out  1  high in every state except IDLE and ERROR
- done  out  1  one-cycle pulse when the last sample is acknowledged
- error  out  1  sticky; set on retry exhaustion
- captured  out  log2(DEPTH)+1  number of samples stored in the current burst
- tx_index  out  log2(DEPTH)  index of the sample currently being sent

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE. All outputs 0. av_writedata=0. Pointers, retry count and timeout counter = 0. Buffer contents undefined.
- States: IDLE, CAPTURE, SEND_LSB, SEND_MSB, WAIT_ACK, DONE, ERROR.
- IDLE/ERROR + start=1: clear captured, tx_index, retry and error; go to CAPTURE next cycle. start in any other state is ignored.
- CAPTURE:
  - Each sample_valid=1 writes sample_data to buffer[captured] and increments captured.
  - When the write that makes captured=DEPTH occurs, go to SEND_LSB next cycle.
  - sample_valid outside CAPTURE is ignored.
  - sample_valid and start in the same cycle while in IDLE: the sample is not stored.
- SEND_LSB: byte = {3'b000, buffer[tx_index][4:0]}.
- SEND_MSB: byte = {3'b111, buffer[tx_index][9:5]}.
- Avalon write handshake:
  - Assert av_write with av_writedata stable.
  - Hold both until the first cycle with av_waitrequest=0; that cycle completes the transfer.
  - av_write drops the next cycle, and the FSM advances (LSB→MSB, MSB→WAIT_ACK) in that same next cycle.
  - Minimum one idle cycle between consecutive writes.
  - av_read and av_write are never high together.
- WAIT_ACK:
  - Timeout counter is cleared on entry. It increments every cycle in WAIT_ACK, including cycles spent in read handshakes.
  - Issue a read: av_read held until av_waitrequest=0; sample av_readdata in that cycle; av_read low the next cycle.
  - Ack = readdata[15]=1 and readdata[7:6]=2'b10.
    - On ack: retry=0. If tx_index=DEPTH-1, go to DONE; else tx_index+1 and go to SEND_LSB.
  - RVALID=0, or a valid byte that is not an ack: discard it and issue another read after one idle cycle.
  - Counter reaches ACK_TIMEOUT-1 with no ack: retry+1. If the new retry equals MAX_RETRY, go to ERROR; else go to SEND_LSB with the same tx_index (resend both bytes).
  - Ack completing in the same cycle the timeout expires: the ack wins.
  - A timeout never interrupts an in-flight read; it takes effect after that read completes.
- DONE: done=1 for exactly one cycle, then IDLE. captured keeps its value until the next start.
- ERROR: error=1, busy=0. Remains here until start or reset.
- reset_n low mid-transfer: av_read and av_write drop immediately (async). The burst is lost; no partial resume.
- captured saturates at DEPTH. tx_index never wraps within a burst.

Test Plan:
- Capture with gaps: start, then 32 sample_valid pulses (data = 10×i) with 0–3 idle cycles between them → captured=32, then the first write is 8'h00 (sample 0), followed by 8'hE0.
- Byte split: sample 10'h3A5 at index 0, av_waitrequest=0 → av_writedata 8'h05 then 8'hFD, one idle cycle between writes, then av_read asserted.
- Waitrequest stall: hold av_waitrequest=1 for 7 cycles during the MSB write → av_write and av_writedata stable all 8 cycles; exactly one transfer counted.
- Ack filtering: during WAIT_ACK return readdata 32'h0 (no RVALID), then 32'h8041 (valid, not an ack), then 32'h8080 → only the third read advances tx_index 0→1 and triggers SEND_LSB.
- Timeout/retry (ACK_TIMEOUT=20, MAX_RETRY=3): never ack sample 5 → sample 5 bytes are sent 3 times, then error=1, busy=0; a start pulse clears error and enters CAPTURE.
- Full burst and reset: ack all 32 samples → done pulses once, state=IDLE. Repeat the run and pull reset_n low during the SEND_MSB of sample 12 → all outputs 0 within the same cycle; a fresh start works normally.
